seg_scan_ctrl: RTL and testbench

//  Time-multiplexes the six stopwatch BCD digits (hr_h..sec_l) onto one shared 7-segment bus.

---
 rtl/seg_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Scans six stopwatch BCD digits onto one shared 7-segment bus.
//               A per-frame snapshot is latched in LOAD so that a frame never
//               mixes two times; freeze holds the snapshot for lap display.
//               Each anode dwells DWELL cycles followed by BLANK dark cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int DWELL   = 4,  // cycles each anode is lit (must be >= 1)
    parameter int BLANK   = 1,  // dark cycles between digits, 0 = none
    parameter int ACT_LOW = 1   // 1: seg/dp/an active-low at the pins
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic       en,
    input  logic       freeze,
    input  logic [3:0] hr_h,
    input  logic [3:0] hr_l,
    input  logic [3:0] min_h,
    input  logic [3:0] min_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] sec_l,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic [2:0] digit_idx,
    output logic       frame_done
);

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic HAS_GAP  = (BLANK != 0);
    localparam logic INV      = (ACT_LOW != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ON   = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_done_q, frame_done_d;
    logic          snap_ld;
    // snapshot packed as {hr_h, hr_l, min_h, min_l, sec_h, sec_l}
    logic [23:0]   snap_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic [5:0]    an_q;

    logic          lit;
    logic [3:0]    dig_val;
    logic [6:0]    seg_l;
    logic          dp_l;
    logic [5:0]    an_l;

    // Logical (active-high) segment pattern; codes 10-15 render a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // State, digit index, dwell counter, frame pulse and snapshot registers
    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            snap_q       <= 24'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
            if (snap_ld) begin
                snap_q <= {hr_h, hr_l, min_h, min_l, sec_h, sec_l};
            end
        end
    end

    // Next-state logic: round-robin over six digits, en=0 forces IDLE
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        snap_ld      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_LOAD;
            end
            S_LOAD: begin
                // freeze keeps the previous snapshot on screen (lap hold)
                snap_ld = !freeze;
                state_d = S_ON;
                idx_d   = 3'd0;
                cnt_d   = '0;
            end
            S_ON: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (HAS_GAP) begin
                        state_d = S_GAP;
                    end else if (idx_q == 3'd5) begin
                        state_d      = S_LOAD;
                        idx_d        = 3'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 3'd5) begin
                        state_d      = S_LOAD;
                        idx_d        = 3'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = S_ON;
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!en) begin
            state_d      = S_IDLE;
            idx_d        = 3'd0;
            cnt_d        = '0;
            frame_done_d = 1'b0;
            snap_ld      = 1'b0;
        end
    end

    // Logical display levels for the digit currently being scanned
    always_comb begin
        lit = en && (state_q == S_ON);
        case (idx_q)
            3'd0:    dig_val = snap_q[3:0];
            3'd1:    dig_val = snap_q[7:4];
            3'd2:    dig_val = snap_q[11:8];
            3'd3:    dig_val = snap_q[15:12];
            3'd4:    dig_val = snap_q[19:16];
            default: dig_val = snap_q[23:20];
        endcase
        an_l  = 6'd0;
        seg_l = 7'd0;
        dp_l  = 1'b0;
        if (lit) begin
            an_l = 6'b000001 << idx_q;
            // leading zero of the hours is blanked, anode still scanned
            if (!(idx_q == 3'd5 && dig_val == 4'd0)) begin
                seg_l = decode(dig_val);
            end
            dp_l = (idx_q == 3'd2) || (idx_q == 3'd4);
        end
    end

    // Pin registers; polarity is applied only here
    always_ff @(posedge Clk) begin
        if (rst) begin
            seg_q <= {7{INV}};
            dp_q  <= INV;
            an_q  <= {6{INV}};
        end else begin
            seg_q <= seg_l ^ {7{INV}};
            dp_q  <= dp_l ^ INV;
            an_q  <= an_l ^ {6{INV}};
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed bench for seg_scan_ctrl. Main instance uses
//               DWELL=4/BLANK=1/ACT_LOW=1; a second instance with BLANK=0 and
//               ACT_LOW=0 shares all inputs for the back-to-back case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    logic       Clk;
    logic       rst, en, freeze;
    logic [3:0] hr_h, hr_l, min_h, min_l, sec_h, sec_l;
    logic [6:0] seg, seg2;
    logic       dp, dp2;
    logic [5:0] an, an2;
    logic [2:0] digit_idx, digit_idx2;
    logic       frame_done, frame_done2;

    int checks;
    int errors;

    seg_scan_ctrl #(.DWELL(4), .BLANK(1), .ACT_LOW(1)) dut (
        .Clk(Clk), .rst(rst), .en(en), .freeze(freeze),
        .hr_h(hr_h), .hr_l(hr_l), .min_h(min_h), .min_l(min_l),
        .sec_h(sec_h), .sec_l(sec_l),
        .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx),
        .frame_done(frame_done)
    );

    seg_scan_ctrl #(.DWELL(4), .BLANK(0), .ACT_LOW(0)) dut2 (
        .Clk(Clk), .rst(rst), .en(en), .freeze(freeze),
        .hr_h(hr_h), .hr_l(hr_l), .min_h(min_h), .min_l(min_l),
        .sec_h(sec_h), .sec_l(sec_l),
        .seg(seg2), .dp(dp2), .an(an2), .digit_idx(digit_idx2),
        .frame_done(frame_done2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // advance n clock edges, landing 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic set_time(input logic [3:0] a, b, c, d, e, f);
        hr_h = a; hr_l = b; min_h = c; min_l = d; sec_h = e; sec_l = f;
    endtask

    // returns at the sample point right after the edge that raises frame_done
    task automatic wait_fd(input bit second);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if ((second ? frame_done2 : frame_done) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_done%0d: got timeout want pulse", second);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; freeze = 1'b0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        step(2);
        checks++; if (an !== 6'h3F) begin errors++; $display("FAIL rst_an: got %h want %h", an, 6'h3F); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg: got %h want %h", seg, 7'h7F); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp: got %b want 1", dp); end
        checks++; if (digit_idx !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", digit_idx); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd: got %b want 0", frame_done); end
        checks++; if (an2 !== 6'h00 || seg2 !== 7'h00) begin errors++; $display("FAIL rst_hi_pol: got an %h seg %h want 00 00", an2, seg2); end
        rst = 1'b0; en = 1'b0;
        step(2);
        checks++; if (an !== 6'h3F) begin errors++; $display("FAIL idle_an: got %h want %h", an, 6'h3F); end
    endtask

    task automatic test_basic();
        en = 1'b1;
        step(1);  // edge k: LOAD
        checks++; if (an !== 6'h3F) begin errors++; $display("FAIL basic_load_an: got %h want %h", an, 6'h3F); end
        step(1);  // k+1
        checks++; if (an !== 6'h3F) begin errors++; $display("FAIL basic_k1_an: got %h want %h", an, 6'h3F); end
        step(1);  // k+2
        checks++; if (an !== 6'h3E) begin errors++; $display("FAIL basic_d0_an: got %h want %h", an, 6'h3E); end
        checks++; if (seg !== 7'h02) begin errors++; $display("FAIL basic_d0_seg: got %h want %h", seg, 7'h02); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL basic_d0_dp: got %b want 1", dp); end
        step(3);  // k+5
        checks++; if (an !== 6'h3E) begin errors++; $display("FAIL basic_d0_last: got %h want %h", an, 6'h3E); end
        step(1);  // k+6 gap
        checks++; if (an !== 6'h3F || seg !== 7'h7F) begin errors++; $display("FAIL basic_gap: got an %h seg %h want 3f 7f", an, seg); end
        step(1);  // k+7
        checks++; if (an !== 6'h3D || seg !== 7'h12) begin errors++; $display("FAIL basic_d1: got an %h seg %h want 3d 12", an, seg); end
        step(23); // k+30
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_early: got %b want 0", frame_done); end
        step(1);  // k+31
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_fd: got %b want 1", frame_done); end
        step(1);  // k+32
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_fd_pulse: got %b want 0", frame_done); end
    endtask

    task automatic test_dp_blank();
        wait_fd(1'b0);  // F
        set_time(4'd0, 4'd7, 4'd3, 4'd4, 4'd5, 4'd6);
        step(3);        // F+3 digit 0
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL dp_d0: got %b want 1", dp); end
        step(5);        // F+8 digit 1
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL dp_d1: got %b want 1", dp); end
        step(5);        // F+13 digit 2
        checks++; if (dp !== 1'b0 || seg !== 7'h19 || an !== 6'h3B) begin errors++; $display("FAIL dp_d2: got dp %b seg %h an %h want 0 19 3b", dp, seg, an); end
        step(5);        // F+18 digit 3
        checks++; if (dp !== 1'b1 || seg !== 7'h30) begin errors++; $display("FAIL dp_d3: got dp %b seg %h want 1 30", dp, seg); end
        step(5);        // F+23 digit 4
        checks++; if (dp !== 1'b0 || seg !== 7'h78 || an !== 6'h2F) begin errors++; $display("FAIL dp_d4: got dp %b seg %h an %h want 0 78 2f", dp, seg, an); end
        step(5);        // F+28 digit 5
        checks++; if (dp !== 1'b1 || seg !== 7'h7F || an !== 6'h1F) begin errors++; $display("FAIL blank_d5: got dp %b seg %h an %h want 1 7f 1f", dp, seg, an); end
    endtask

    task automatic test_tear_free();
        wait_fd(1'b0);  // F
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        step(1);        // F+1 snapshot taken
        sec_l = 4'd7;
        step(2);        // F+3
        checks++; if (seg !== 7'h02) begin errors++; $display("FAIL tear_cur: got %h want %h", seg, 7'h02); end
        wait_fd(1'b0);
        step(3);
        checks++; if (seg !== 7'h78) begin errors++; $display("FAIL tear_next: got %h want %h", seg, 7'h78); end
    endtask

    task automatic test_freeze();
        logic [3:0] live [3];
        live[0] = 4'd8; live[1] = 4'd9; live[2] = 4'd0;
        freeze = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_fd(1'b0);
            sec_l = live[f];
            step(3);
            checks++; if (seg !== 7'h78) begin errors++; $display("FAIL freeze_f%0d: got %h want %h", f, seg, 7'h78); end
        end
        wait_fd(1'b0);
        freeze = 1'b0;
        sec_l  = 4'd1;
        step(3);
        checks++; if (seg !== 7'h79) begin errors++; $display("FAIL freeze_release: got %h want %h", seg, 7'h79); end
    endtask

    task automatic test_en_drop();
        bit saw;
        wait_fd(1'b0);  // F
        step(18);       // digit 3 ON
        checks++; if (an !== 6'h37 || digit_idx !== 3'd3) begin errors++; $display("FAIL drop_pre: got an %h idx %0d want 37 3", an, digit_idx); end
        en = 1'b0;
        step(1);
        checks++; if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL drop_dark: got an %h seg %h dp %b want 3f 7f 1", an, seg, dp); end
        checks++; if (digit_idx !== 3'd0 || frame_done !== 1'b0) begin errors++; $display("FAIL drop_idx: got idx %0d fd %b want 0 0", digit_idx, frame_done); end
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (frame_done !== 1'b0 || an !== 6'h3F) saw = 1'b1;
        end
        checks++; if (saw) begin errors++; $display("FAIL drop_quiet: got activity want none"); end
        en = 1'b1;
        step(1);        // LOAD
        checks++; if (an !== 6'h3F || digit_idx !== 3'd0) begin errors++; $display("FAIL reen_load: got an %h idx %0d want 3f 0", an, digit_idx); end
        step(2);
        checks++; if (an !== 6'h3E || seg !== 7'h79) begin errors++; $display("FAIL reen_d0: got an %h seg %h want 3e 79", an, seg); end
    endtask

    task automatic test_back_to_back();
        sec_l = 4'hC;
        wait_fd(1'b1);  // F on the BLANK=0 instance
        step(2);        // F+2
        checks++; if (an2 !== 6'h01 || seg2 !== 7'h40 || dp2 !== 1'b0) begin errors++; $display("FAIL b2b_d0: got an %h seg %h dp %b want 01 40 0", an2, seg2, dp2); end
        step(3);        // F+5
        checks++; if (an2 !== 6'h01) begin errors++; $display("FAIL b2b_d0_last: got %h want 01", an2); end
        step(1);        // F+6
        checks++; if (an2 !== 6'h02 || seg2 !== 7'h6D) begin errors++; $display("FAIL b2b_d1: got an %h seg %h want 02 6d", an2, seg2); end
        step(4);        // F+10
        checks++; if (an2 !== 6'h04 || seg2 !== 7'h66 || dp2 !== 1'b1) begin errors++; $display("FAIL b2b_d2: got an %h seg %h dp %b want 04 66 1", an2, seg2, dp2); end
        step(14);       // F+24
        checks++; if (frame_done2 !== 1'b0) begin errors++; $display("FAIL b2b_fd_early: got %b want 0", frame_done2); end
        step(1);        // F+25
        checks++; if (frame_done2 !== 1'b1) begin errors++; $display("FAIL b2b_frame_len: got %b want 1", frame_done2); end
        wait_fd(1'b0);
        step(3);
        checks++; if (seg !== 7'h3F) begin errors++; $display("FAIL dash_act_low: got %h want %h", seg, 7'h3F); end
    endtask

    task automatic test_rst_mid();
        step(7);
        rst = 1'b1;
        step(1);
        checks++; if (an !== 6'h3F || seg !== 7'h7F || digit_idx !== 3'd0 || frame_done !== 1'b0) begin errors++; $display("FAIL rstmid: got an %h seg %h idx %0d fd %b want 3f 7f 0 0", an, seg, digit_idx, frame_done); end
        freeze = 1'b1;  // hold the cleared snapshot
        rst    = 1'b0;
        step(3);        // k+2
        checks++; if (an !== 6'h3E || seg !== 7'h40) begin errors++; $display("FAIL rstmid_snap0: got an %h seg %h want 3e 40", an, seg); end
        step(25);       // k+27 digit 5, zero blanked
        checks++; if (an !== 6'h1F || seg !== 7'h7F) begin errors++; $display("FAIL rstmid_d5: got an %h seg %h want 1f 7f", an, seg); end
        freeze = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b0; freeze = 1'b0;
        set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_basic();
        test_dp_blank();
        test_tear_free();
        test_freeze();
        test_en_drop();
        test_back_to_back();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
